wand_bus_arbiter: RTL and testbench

WAND_BUS_ARBITER -- requirements
Module: wand_bus_arbiter

---
 rtl/wand_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_wand_bus_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/wand_bus_arbiter.sv
// wand_bus_arbiter: round-robin owner selection for a shared wired-AND line.
// One requester at a time may drive the line. An owner keeps the grant for at
// most MAX_HOLD cycles. Every grant ends with a single RELEASE turnaround
// cycle, during which no requester is granted.
module wand_bus_arbiter #(
   parameter int unsigned N        = 4,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic [N-1:0] d,
   output logic [N-1:0] gnt,
   output logic         bus_y,
   output logic         busy,
   output logic         timeout
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t          r_state;
   logic [N-1:0]    r_gnt;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_owner;
   logic [CW-1:0]   r_cnt;
   logic            r_busy;
   logic            r_timeout;

   logic            w_found;
   logic [PW-1:0]   w_sel;
   logic [PW-1:0]   w_idx;
   logic [N-1:0]    w_gnt_new;
   logic            w_owner_req;
   logic            w_cnt_last;
   logic [PW-1:0]   w_ptr_next;

   // Round-robin search: first requester at or after ptr, wrapping modulo N
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_idx   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_idx = PW'((32'(r_ptr) + k) % N);
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_sel   = w_idx;
         end
      end
   end

   assign w_gnt_new   = {{(N-1){1'b0}}, 1'b1} << w_sel;
   assign w_owner_req = req[r_owner];
   assign w_cnt_last  = (r_cnt == CNT_LAST);
   assign w_ptr_next  = (r_owner == PTR_LAST) ? '0 : r_owner + PW'(1);

   // Arbitration FSM with registered grant, busy and timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_gnt     <= '0;
         r_ptr     <= '0;
         r_owner   <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state <= S_GRANT;
                  r_gnt   <= w_gnt_new;
                  r_owner <= w_sel;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_GRANT: begin
               // A dropped request wins over the hold limit, so no timeout
               if (!w_owner_req) begin
                  r_state <= S_RELEASE;
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
               end else if (w_cnt_last) begin
                  r_state   <= S_RELEASE;
                  r_gnt     <= '0;
                  r_busy    <= 1'b0;
                  r_timeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_RELEASE: begin
               r_state <= S_IDLE;
               r_ptr   <= w_ptr_next;
            end
            default: begin
               r_state <= S_IDLE;
               r_gnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // A requester without the grant reads as 1, so its d cannot pull the line
   assign bus_y   = &(d | ~r_gnt);
   assign gnt     = r_gnt;
   assign busy    = r_busy;
   assign timeout = r_timeout;

endmodule

// File: tb/tb_wand_bus_arbiter.sv
// Directed bench for wand_bus_arbiter (N=4, MAX_HOLD=8): a vector table plus
// hand-written multi-cycle sequences.
module tb_wand_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] d   = 4'b1111;
   logic [3:0] gnt;
   logic       bus_y;
   logic       busy;
   logic       timeout;

   int n_checks = 0;
   int n_errors = 0;

   wand_bus_arbiter #(.N(4), .MAX_HOLD(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .d       (d),
      .gnt     (gnt),
      .bus_y   (bus_y),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic [3:0] d;
      logic [3:0] gnt;
      logic       busy;
      logic       timeout;
      logic       bus_y;
   } vec_t;

   localparam int NV = 27;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [3:0] eg, input logic eb,
                            input logic et, input logic ey);
      check({tag, ".gnt"}, 32'(gnt), 32'(eg));
      check({tag, ".busy"}, 32'(busy), 32'(eb));
      check({tag, ".timeout"}, 32'(timeout), 32'(et));
      check({tag, ".bus_y"}, 32'(bus_y), 32'(ey));
   endtask

   // Grant must be at most one-hot in every cycle
   always @(negedge clk) begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
   end

   initial begin
      // Each row: inputs applied before an edge; outputs expected after it
      //           req      d        gnt      busy  tmo   bus_y
      vecs[0]  = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b1}; // IDLE->GRANT 0
      vecs[1]  = '{4'b1111, 4'b1110, 4'b0001, 1'b1, 1'b0, 1'b0}; // owner pulls low
      vecs[2]  = '{4'b1110, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1}; // drop -> RELEASE
      vecs[3]  = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1}; // IDLE
      vecs[4]  = '{4'b1111, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1}; // gnt 1, d=0010
      vecs[5]  = '{4'b1111, 4'b1101, 4'b0010, 1'b1, 1'b0, 1'b0}; // gnt 1, d=1101
      vecs[6]  = '{4'b1101, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1}; // RELEASE, d=0
      vecs[7]  = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{4'b1111, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1}; // others' d ignored
      vecs[9]  = '{4'b1111, 4'b1111, 4'b0100, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{4'b1011, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1};
      vecs[12] = '{4'b1111, 4'b1111, 4'b1000, 1'b1, 1'b0, 1'b1};
      vecs[13] = '{4'b1111, 4'b0111, 4'b1000, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{4'b0111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1};
      vecs[15] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1}; // ptr wrapped to 0
      vecs[16] = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b1};
      vecs[17] = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b1};
      vecs[18] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1};
      vecs[19] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1}; // IDLE, ptr=1
      vecs[20] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1}; // stay IDLE
      vecs[21] = '{4'b1000, 4'b1111, 4'b1000, 1'b1, 1'b0, 1'b1}; // owner 3
      vecs[22] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1};
      vecs[23] = '{4'b1001, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1}; // ptr wraps to 0
      vecs[24] = '{4'b1001, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b1}; // 0001, not 1000
      vecs[25] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1};
      vecs[26] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1}; // IDLE, ptr=1

      // Asynchronous reset at start, before any clock edge
      #1 rst = 1'b1;
      #2;
      check_all("reset_async", 4'b0000, 1'b0, 1'b0, 1'b1);
      step();
      step();
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         req = vecs[i].req;
         d   = vecs[i].d;
         step();
         check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].busy,
                   vecs[i].timeout, vecs[i].bus_y);
      end

      // Hold limit: no grant in the cycle req rises, then exactly 8 grant cycles
      d   = 4'b1111;
      req = 4'b0001;
      #1;
      check("latency_no_same_cycle", 32'(gnt), 32'd0);
      step();
      for (int i = 0; i < 8; i++) begin
         check_all($sformatf("hold%0d", i), 4'b0001, 1'b1, 1'b0, 1'b1);
         if (i < 7) step();
      end
      step();
      check_all("hold_release", 4'b0000, 1'b0, 1'b1, 1'b1);
      step();
      check_all("hold_idle", 4'b0000, 1'b0, 1'b0, 1'b1);
      step();
      check_all("hold_regrant", 4'b0001, 1'b1, 1'b0, 1'b1);

      // Owner drops req in its cnt=7 cycle: the drop wins, no timeout
      for (int i = 1; i < 8; i++) begin
         step();
         check($sformatf("simul_hold%0d", i), 32'(gnt), 32'h1);
      end
      req = 4'b0000;
      step();
      check_all("simul_release", 4'b0000, 1'b0, 1'b0, 1'b1);

      // Reset mid-grant drops gnt without a clock edge
      req = 4'b0100;
      step();
      step();
      check_all("pre_reset_grant", 4'b0100, 1'b1, 1'b0, 1'b1);
      #2 rst = 1'b1;
      #1;
      check_all("reset_mid_grant", 4'b0000, 1'b0, 1'b0, 1'b1);
      step();
      check_all("reset_held", 4'b0000, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      req = 4'b1111;
      step();
      check_all("post_reset_ptr0", 4'b0001, 1'b1, 1'b0, 1'b1);
      step();
      check_all("post_reset_hold", 4'b0001, 1'b1, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
